riscv_writeback_unit: RTL and testbench
=======================================

Name: riscv_writeback_unit

Overview:
- Writeback stage of the multicycle RISC-V core, directly upstream of the register file.
- Accepts one retiring instruction per handshake and selects the result source: ALU, load, PC+4 or immediate.
- For loads, waits for the data-memory response, then aligns and sign/zero-extends the data.
- Drives the register file write port as a single-cycle pulse and counts retired instructions.

Parameters:
CNT_W, 64, width of the instret retire counter
TIMEOUT_CYCLES, 255, max cycles spent in WAIT_LOAD before a fault; 0 disables the timeout

Ports:
wb_clk  input  1  clock, all state updates on its rising edge
wb_rst  input  1  reset, synchronous, active-high
req_valid  input  1  upstream has a retiring instruction
req_ready  output  1  unit can accept a request
req_wen  input  1  instruction writes rd
req_rd  input  5  destination register index
req_sel  input  2  result source: 0 ALU, 1 LOAD, 2 PC+4, 3 IMM
req_alu_result  input  32  ALU result
req_pc_plus4  input  32  PC+4 (JAL/JALR link value)
req_imm  input  32  U-type immediate (LUI)
req_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
req_addr_lo  input  2  load address bits [1:0]
mem_rsp_valid  input  1  data-memory response valid, 1-cycle pulse
mem_rsp_err  input  1  bus error, qualified by mem_rsp_valid
mem_rsp_data  input  32  aligned 32-bit word read from memory
wb_we  output  1  register file write enable
write_addr  output  5  register file write index
write_data  output  32  register file write data
done  output  1  1-cycle pulse: instruction retired or faulted
load_fault  output  1  qualifies done: instruction faulted, no write
instret  output  CNT_W  count of successfully retired instructions

Behaviour:
- States: IDLE, WAIT_LOAD, WRITE, FAULT. Reset → IDLE.
- On reset, all outputs are 0 except req_ready, which is 1. Reset clears instret and the timeout counter and discards any pending request or response.
- IDLE:
  - req_ready=1, and req_ready is 1 only in IDLE.
  - On req_valid, capture all req_* fields.
  - If sel≠LOAD: go to WRITE.
  - If sel=LOAD with illegal funct3 (011, 110, 111), LH/LHU with addr_lo[0]=1, or LW with addr_lo≠00: go to FAULT without waiting for memory.
  - Any other LOAD: go to WAIT_LOAD with the timeout counter cleared.
- WAIT_LOAD:
  - On mem_rsp_valid with mem_rsp_err=1: go to FAULT.
  - On mem_rsp_valid with mem_rsp_err=0: latch the extracted data and go to WRITE.
  - Otherwise increment the timeout counter. When TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES: go to FAULT.
  - mem_rsp_valid in any other state is ignored.
- Load extraction:
  - Byte = data[8*addr_lo +: 8].
  - Half = data[16*addr_lo[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- WRITE (exactly 1 cycle, then IDLE):
  - wb_we = req_wen && rd≠0.
  - write_addr = rd; write_data = selected value.
  - done=1, load_fault=0, instret += 1 (also when wb_we=0).
- FAULT (exactly 1 cycle, then IDLE): done=1, load_fault=1, wb_we=0, instret unchanged.
- Outside WRITE, wb_we=0 and write_addr/write_data=0.
- Latency:
  - Non-load accepted in cycle N → wb_we/done in cycle N+1.
  - Load response in cycle M → wb_we/done in cycle M+1.
  - Back-to-back non-loads sustain 1 instruction per 2 cycles.
- instret wraps modulo 2^CNT_W.

Test Plan:
- ALU op: req_sel=0, rd=5, alu_result=0xDEADBEEF → next cycle wb_we=1, write_addr=5, write_data=0xDEADBEEF, done=1, instret 0→1.
- x0 / no-write: rd=0, or req_wen=0 → wb_we=0 in WRITE, done=1, instret increments.
- Byte load: LB with addr_lo=2, response 3 cycles after accept carrying 0x0080FF00 → write_data=0xFFFFFF80. Same transaction as LBU → 0x00000080. LHU with addr_lo=2 → 0x00000080.
- Faults, each giving done=1, load_fault=1, wb_we=0, instret unchanged, req_ready=1 on the next cycle:
  - LW with addr_lo=01.
  - funct3=011.
  - Response with mem_rsp_err=1.
  - No response within TIMEOUT_CYCLES=4.
- Reset mid-load: wb_rst asserted in WAIT_LOAD, then a late mem_rsp_valid → no write, state IDLE, instret=0, req_ready=1.
- Sources and throughput: PC+4 select (pc_plus4=0x104) and IMM select (imm=0x12345000) → correct write_data. Spurious mem_rsp_valid while IDLE → no effect. Continuous req_valid for non-loads → accepts every other cycle.

Source files
------------

// File: rtl/riscv_writeback_unit.sv
// riscv_writeback_unit: writeback stage that selects the result source, finishes loads and drives the register file write port
//
// Ports:
//    wb_clk, wb_rst              clock and synchronous active-high reset
//    req_valid / req_ready       one retiring instruction per handshake, ready only in IDLE
//    req_wen, req_rd, req_sel    write enable, destination and result source (ALU, LOAD, PC+4, IMM)
//    req_alu_result, req_pc_plus4, req_imm   candidate result values
//    req_funct3, req_addr_lo     load type and byte offset within the word
//    mem_rsp_valid/err/data      data-memory response, only looked at while waiting for a load
//    wb_we, write_addr, write_data   register file write port, a single-cycle pulse
//    done, load_fault            retire/fault pulse, load_fault qualifies done
//    instret                     successfully retired instruction count
module riscv_writeback_unit #(
   parameter int unsigned CNT_W          = 64,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic             wb_clk,
   input  logic             wb_rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_wen,
   input  logic [4:0]       req_rd,
   input  logic [1:0]       req_sel,
   input  logic [31:0]      req_alu_result,
   input  logic [31:0]      req_pc_plus4,
   input  logic [31:0]      req_imm,
   input  logic [2:0]       req_funct3,
   input  logic [1:0]       req_addr_lo,
   input  logic             mem_rsp_valid,
   input  logic             mem_rsp_err,
   input  logic [31:0]      mem_rsp_data,
   output logic             wb_we,
   output logic [4:0]       write_addr,
   output logic [31:0]      write_data,
   output logic             done,
   output logic             load_fault,
   output logic [CNT_W-1:0] instret
);
   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [1:0] SEL_ALU  = 2'd0;
   localparam logic [1:0] SEL_LOAD = 2'd1;
   localparam logic [1:0] SEL_PC4  = 2'd2;
   typedef enum logic [1:0] {IDLE, WAIT_LOAD, WRITE, FAULT} state_t;
   state_t           state_q, state_d;
   logic             wen_q, wen_d;
   logic [4:0]       rd_q, rd_d;
   logic [1:0]       sel_q, sel_d;
   logic [31:0]      alu_q, alu_d;
   logic [31:0]      pc4_q, pc4_d;
   logic [31:0]      imm_q, imm_d;
   logic [2:0]       funct3_q, funct3_d;
   logic [1:0]       addr_lo_q, addr_lo_d;
   logic [31:0]      load_q, load_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             bad_load;
   logic [31:0]      byte_sh;
   logic [15:0]      half;
   logic [31:0]      load_ext;
   logic [31:0]      result;
   // Misaligned or undefined loads are rejected before memory is consulted.
   assign bad_load = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111) ||
                     (((req_funct3 == 3'b001) || (req_funct3 == 3'b101)) && req_addr_lo[0]) ||
                     ((req_funct3 == 3'b010) && (req_addr_lo != 2'b00));
   assign byte_sh  = mem_rsp_data >> {addr_lo_q, 3'b000};
   assign half     = addr_lo_q[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
   assign load_ext = (funct3_q == 3'b000) ? {{24{byte_sh[7]}}, byte_sh[7:0]} :
                     (funct3_q == 3'b001) ? {{16{half[15]}}, half} :
                     (funct3_q == 3'b100) ? {24'd0, byte_sh[7:0]} :
                     (funct3_q == 3'b101) ? {16'd0, half} : mem_rsp_data;
   assign result   = (sel_q == SEL_ALU)  ? alu_q :
                     (sel_q == SEL_LOAD) ? load_q :
                     (sel_q == SEL_PC4)  ? pc4_q : imm_q;
   always_comb begin
      state_d   = state_q;
      wen_d     = wen_q;
      rd_d      = rd_q;
      sel_d     = sel_q;
      alu_d     = alu_q;
      pc4_d     = pc4_q;
      imm_d     = imm_q;
      funct3_d  = funct3_q;
      addr_lo_d = addr_lo_q;
      load_d    = load_q;
      tmo_d     = tmo_q;
      instret_d = instret_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               wen_d     = req_wen;
               rd_d      = req_rd;
               sel_d     = req_sel;
               alu_d     = req_alu_result;
               pc4_d     = req_pc_plus4;
               imm_d     = req_imm;
               funct3_d  = req_funct3;
               addr_lo_d = req_addr_lo;
               tmo_d     = '0;
               state_d   = (req_sel != SEL_LOAD) ? WRITE : bad_load ? FAULT : WAIT_LOAD;
            end
         end
         WAIT_LOAD: begin
            if (mem_rsp_valid) begin
               state_d = mem_rsp_err ? FAULT : WRITE;
               load_d  = mem_rsp_err ? load_q : load_ext;
            end else begin
               tmo_d = tmo_q + TW'(1);
               if ((TIMEOUT_CYCLES != 0) && (tmo_d == TW'(TIMEOUT_CYCLES)))
                  state_d = FAULT;
            end
         end
         WRITE: begin
            state_d   = IDLE;
            instret_d = instret_q + CNT_W'(1);
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state_q   <= IDLE;
         wen_q     <= 1'b0;
         rd_q      <= '0;
         sel_q     <= '0;
         alu_q     <= '0;
         pc4_q     <= '0;
         imm_q     <= '0;
         funct3_q  <= '0;
         addr_lo_q <= '0;
         load_q    <= '0;
         tmo_q     <= '0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         wen_q     <= wen_d;
         rd_q      <= rd_d;
         sel_q     <= sel_d;
         alu_q     <= alu_d;
         pc4_q     <= pc4_d;
         imm_q     <= imm_d;
         funct3_q  <= funct3_d;
         addr_lo_q <= addr_lo_d;
         load_q    <= load_d;
         tmo_q     <= tmo_d;
         instret_q <= instret_d;
      end
   end
   assign req_ready  = (state_q == IDLE);
   assign wb_we      = (state_q == WRITE) && wen_q && (rd_q != 5'd0);
   assign write_addr = (state_q == WRITE) ? rd_q : 5'd0;
   assign write_data = (state_q == WRITE) ? result : 32'd0;
   assign done       = (state_q == WRITE) || (state_q == FAULT);
   assign load_fault = (state_q == FAULT);
   assign instret    = instret_q;
endmodule

// File: tb/tb_riscv_writeback_unit.sv
// tb_riscv_writeback_unit: directed self-checking bench for the writeback unit
module tb_riscv_writeback_unit;
   logic        wb_clk = 1'b0;
   logic        wb_rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wen = 1'b0;
   logic [4:0]  req_rd = '0;
   logic [1:0]  req_sel = '0;
   logic [31:0] req_alu_result = '0;
   logic [31:0] req_pc_plus4 = '0;
   logic [31:0] req_imm = '0;
   logic [2:0]  req_funct3 = '0;
   logic [1:0]  req_addr_lo = '0;
   logic        mem_rsp_valid = 1'b0;
   logic        mem_rsp_err = 1'b0;
   logic [31:0] mem_rsp_data = '0;
   logic        wb_we;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic        done;
   logic        load_fault;
   logic [63:0] instret;
   int vecs = 0;
   int miss = 0;
   riscv_writeback_unit #(.CNT_W(64), .TIMEOUT_CYCLES(4)) dut (
      .wb_clk(wb_clk), .wb_rst(wb_rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_rd(req_rd),
      .req_sel(req_sel), .req_alu_result(req_alu_result), .req_pc_plus4(req_pc_plus4),
      .req_imm(req_imm), .req_funct3(req_funct3), .req_addr_lo(req_addr_lo),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_err(mem_rsp_err), .mem_rsp_data(mem_rsp_data),
      .wb_we(wb_we), .write_addr(write_addr), .write_data(write_data),
      .done(done), .load_fault(load_fault), .instret(instret)
   );
   always #5 wb_clk = ~wb_clk;
   task automatic step();
      @(posedge wb_clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic outs(input string tag, input logic we, input logic [4:0] addr, input logic [31:0] data,
                       input logic dn, input logic lf, input logic rdy);
      chk({tag, ".we"}, 64'(wb_we), 64'(we));
      chk({tag, ".addr"}, 64'(write_addr), 64'(addr));
      chk({tag, ".data"}, 64'(write_data), 64'(data));
      chk({tag, ".done"}, 64'(done), 64'(dn));
      chk({tag, ".fault"}, 64'(load_fault), 64'(lf));
      chk({tag, ".ready"}, 64'(req_ready), 64'(rdy));
   endtask
   task automatic send(input logic [1:0] sel, input logic wen, input logic [4:0] rd, input logic [31:0] val,
                       input logic [2:0] f3, input logic [1:0] alo);
      req_sel = sel;
      req_wen = wen;
      req_rd = rd;
      req_alu_result = (sel == 2'd0) ? val : 32'hA5A5A5A5;
      req_pc_plus4 = (sel == 2'd2) ? val : 32'h5A5A5A5A;
      req_imm = (sel == 2'd3) ? val : 32'h3C3C3C3C;
      req_funct3 = f3;
      req_addr_lo = alo;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
   endtask
   task automatic respond(input int gap, input logic err, input logic [31:0] data);
      for (int i = 1; i < gap; i++) step();
      mem_rsp_valid = 1'b1;
      mem_rsp_err = err;
      mem_rsp_data = data;
      step();
      mem_rsp_valid = 1'b0;
      mem_rsp_err = 1'b0;
   endtask
   initial begin
      step();
      step();
      outs("reset", 0, 0, 0, 0, 0, 1);
      chk("reset.instret", instret, 0);
      wb_rst = 1'b0;
      send(2'd0, 1, 5'd5, 32'hDEADBEEF, 3'b000, 2'd0);
      outs("alu", 1, 5, 32'hDEADBEEF, 1, 0, 0);
      chk("alu.instret_pre", instret, 0);
      step();
      outs("alu.after", 0, 0, 0, 0, 0, 1);
      chk("alu.instret", instret, 1);
      send(2'd0, 1, 5'd0, 32'h11111111, 3'b000, 2'd0);
      outs("x0", 0, 0, 32'h11111111, 1, 0, 0);
      step();
      chk("x0.instret", instret, 2);
      send(2'd0, 0, 5'd7, 32'h22222222, 3'b000, 2'd0);
      outs("nowen", 0, 7, 32'h22222222, 1, 0, 0);
      step();
      chk("nowen.instret", instret, 3);
      send(2'd1, 1, 5'd8, 32'd0, 3'b000, 2'd2);
      outs("lb.wait", 0, 0, 0, 0, 0, 0);
      respond(3, 0, 32'h0080FF00);
      outs("lb", 1, 8, 32'hFFFFFF80, 1, 0, 0);
      step();
      chk("lb.instret", instret, 4);
      send(2'd1, 1, 5'd9, 32'd0, 3'b100, 2'd2);
      respond(3, 0, 32'h0080FF00);
      outs("lbu", 1, 9, 32'h00000080, 1, 0, 0);
      step();
      send(2'd1, 1, 5'd10, 32'd0, 3'b101, 2'd2);
      respond(3, 0, 32'h0080FF00);
      outs("lhu", 1, 10, 32'h00000080, 1, 0, 0);
      step();
      send(2'd1, 1, 5'd11, 32'd0, 3'b001, 2'd0);
      respond(1, 0, 32'h0080FF00);
      outs("lh", 1, 11, 32'hFFFFFF00, 1, 0, 0);
      step();
      send(2'd1, 1, 5'd12, 32'd0, 3'b010, 2'd0);
      respond(2, 0, 32'h0080FF00);
      outs("lw", 1, 12, 32'h0080FF00, 1, 0, 0);
      step();
      chk("loads.instret", instret, 8);
      send(2'd1, 1, 5'd13, 32'd0, 3'b010, 2'd1);
      outs("lw_mis", 0, 0, 0, 1, 1, 0);
      step();
      outs("lw_mis.after", 0, 0, 0, 0, 0, 1);
      chk("lw_mis.instret", instret, 8);
      send(2'd1, 1, 5'd13, 32'd0, 3'b011, 2'd0);
      outs("f3_011", 0, 0, 0, 1, 1, 0);
      step();
      chk("f3_011.ready", 64'(req_ready), 1);
      chk("f3_011.instret", instret, 8);
      send(2'd1, 1, 5'd14, 32'd0, 3'b010, 2'd0);
      respond(2, 1, 32'hFFFFFFFF);
      outs("buserr", 0, 0, 0, 1, 1, 0);
      step();
      chk("buserr.ready", 64'(req_ready), 1);
      chk("buserr.instret", instret, 8);
      send(2'd1, 1, 5'd15, 32'd0, 3'b000, 2'd0);
      step();
      step();
      step();
      outs("tmo.pre", 0, 0, 0, 0, 0, 0);
      step();
      outs("tmo", 0, 0, 0, 1, 1, 0);
      step();
      chk("tmo.ready", 64'(req_ready), 1);
      chk("tmo.instret", instret, 8);
      send(2'd1, 1, 5'd16, 32'd0, 3'b010, 2'd0);
      step();
      wb_rst = 1'b1;
      step();
      wb_rst = 1'b0;
      respond(1, 0, 32'h12345678);
      outs("rst_mid", 0, 0, 0, 0, 0, 1);
      chk("rst_mid.instret", instret, 0);
      step();
      outs("rst_mid.later", 0, 0, 0, 0, 0, 1);
      send(2'd2, 1, 5'd1, 32'h00000104, 3'b000, 2'd0);
      outs("pc4", 1, 1, 32'h00000104, 1, 0, 0);
      step();
      send(2'd3, 1, 5'd2, 32'h12345000, 3'b000, 2'd0);
      outs("imm", 1, 2, 32'h12345000, 1, 0, 0);
      step();
      chk("srcs.instret", instret, 2);
      respond(1, 0, 32'hCAFEF00D);
      outs("spurious", 0, 0, 0, 0, 0, 1);
      chk("spurious.instret", instret, 2);
      req_sel = 2'd0;
      req_wen = 1'b1;
      req_rd = 5'd3;
      req_alu_result = 32'h00000011;
      req_valid = 1'b1;
      step();
      outs("tput1", 1, 3, 32'h00000011, 1, 0, 0);
      step();
      outs("tput1.gap", 0, 0, 0, 0, 0, 1);
      req_alu_result = 32'h00000022;
      step();
      outs("tput2", 1, 3, 32'h00000022, 1, 0, 0);
      req_valid = 1'b0;
      step();
      outs("tput2.gap", 0, 0, 0, 0, 0, 1);
      chk("tput.instret", instret, 4);
      step();
      outs("tput.idle", 0, 0, 0, 0, 0, 1);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule
